bn_param_buf: RTL and testbench

- Receiving end of the BN parameter MEM write port (bn_mem_wen_a/addr_a/din_a) driven by the config/sim master.
- Stores per-channel {B, A} batch-norm parameters in an on-chip RAM.
- Serves them to the BN/activation unit over a valid/ready read-request/response pair.
- Applies the bn_is_a_eq_1 / bn_is_b_eq_0 overrides on the read path.

---
 rtl/bn_param_buf.sv | 163 ++++++++++++++++
 tb/tb_bn_param_buf.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bn_param_buf.sv
// Batch-norm parameter store: config-port writes, pipelined reads with
// override logic and a 3-entry response FIFO toward the BN/act unit.
module bn_param_buf #(
    parameter int BN_MEM_DEPTH = 512,
    parameter int BN_ADDR_W    = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_bn_act_proc,
    input  logic [1:0]  calfmt,
    input  logic [4:0]  bn_fixed_point_quat_accrc,
    input  logic        bn_is_a_eq_1,
    input  logic        bn_is_b_eq_0,
    input  logic        bn_mem_wen_a,
    input  logic [15:0] bn_mem_addr_a,
    input  logic [63:0] bn_mem_din_a,
    input  logic        rd_req_valid,
    output logic        rd_req_ready,
    input  logic [15:0] rd_req_cid,
    input  logic        rd_req_last,
    output logic        bn_param_valid,
    input  logic        bn_param_ready,
    output logic [31:0] bn_param_a,
    output logic [31:0] bn_param_b,
    output logic        bn_param_last,
    output logic        bn_param_oor
);

    logic [63:0] mem [BN_MEM_DEPTH];

    logic        wr_ok;
    logic        accept;
    logic        req_oor;
    logic        run_q;

    logic        p_valid;
    logic        p_last;
    logic        p_oor;
    logic [63:0] p_data;

    logic        s1_valid;
    logic        s1_last;
    logic        s1_oor;
    logic [63:0] s1_data;

    logic [31:0] f_a    [3];
    logic [31:0] f_b    [3];
    logic        f_last [3];
    logic        f_oor  [3];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [1:0]  cnt;

    logic        push;
    logic        pop;
    logic [2:0]  occ;
    logic [31:0] one_val;
    logic [31:0] push_a;
    logic [31:0] push_b;

    assign wr_ok = bn_mem_wen_a
                 & ({1'b0, bn_mem_addr_a} < 17'(BN_MEM_DEPTH));
    assign req_oor = ({1'b0, rd_req_cid} >= 17'(BN_MEM_DEPTH));

    // Occupancy counts both pipeline stages so a held-off FIFO never overflows
    assign occ = {2'b00, p_valid} + {2'b00, s1_valid} + {1'b0, cnt};
    assign rd_req_ready = run_q & en_bn_act_proc & (occ < 3'd3);
    assign accept = rd_req_valid & rd_req_ready;

    assign push = s1_valid;
    assign pop  = (cnt != 2'd0) & bn_param_ready;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bn_mem_addr_a[BN_ADDR_W-1:0]] <= bn_mem_din_a;
        end
    end

    always_comb begin
        one_val = 32'd1 << bn_fixed_point_quat_accrc;
        if (calfmt == 2'd2) begin
            one_val = 32'h3F80_0000;
        end
        push_a = s1_oor ? 32'd0 : s1_data[31:0];
        if (bn_is_a_eq_1) begin
            push_a = one_val;
        end
        push_b = s1_data[63:32];
        if (bn_is_b_eq_0 | s1_oor) begin
            push_b = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            p_valid  <= 1'b0;
            p_last   <= 1'b0;
            p_oor    <= 1'b0;
            p_data   <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_oor   <= 1'b0;
            s1_data  <= '0;
        end else begin
            run_q    <= 1'b1;
            p_valid  <= accept;
            s1_valid <= p_valid & en_bn_act_proc;
            if (accept) begin
                // Read-first: a same-edge write lands after this sample
                p_data <= mem[rd_req_cid[BN_ADDR_W-1:0]];
                p_last <= rd_req_last;
                p_oor  <= req_oor;
            end
            if (p_valid) begin
                s1_data <= p_data;
                s1_last <= p_last;
                s1_oor  <= p_oor;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                f_a[i]    <= '0;
                f_b[i]    <= '0;
                f_last[i] <= 1'b0;
                f_oor[i]  <= 1'b0;
            end
        end else if (!en_bn_act_proc) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                f_a[wr_ptr]    <= push_a;
                f_b[wr_ptr]    <= push_b;
                f_last[wr_ptr] <= s1_last;
                f_oor[wr_ptr]  <= s1_oor;
                wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign bn_param_valid = (cnt != 2'd0);
    assign bn_param_a    = bn_param_valid ? f_a[rd_ptr]    : 32'd0;
    assign bn_param_b    = bn_param_valid ? f_b[rd_ptr]    : 32'd0;
    assign bn_param_last = bn_param_valid ? f_last[rd_ptr] : 1'b0;
    assign bn_param_oor  = bn_param_valid ? f_oor[rd_ptr]  : 1'b0;

endmodule

// File: tb/tb_bn_param_buf.sv
// Directed bench for bn_param_buf with a queue-based reference model
// checked against the response port on every cycle.
module tb_bn_param_buf;

    typedef struct packed {
        logic        last;
        logic        oor;
        logic [31:0] b;
        logic [31:0] a;
    } rsp_t;

    logic        clk;
    logic        rst_n;
    logic        en_bn_act_proc;
    logic [1:0]  calfmt;
    logic [4:0]  quat;
    logic        a_eq_1;
    logic        b_eq_0;
    logic        wen;
    logic [15:0] waddr;
    logic [63:0] wdin;
    logic        rd_req_valid;
    logic        rd_req_ready;
    logic [15:0] rd_req_cid;
    logic        rd_req_last;
    logic        bn_param_valid;
    logic        bn_param_ready;
    logic [31:0] bn_param_a;
    logic [31:0] bn_param_b;
    logic        bn_param_last;
    logic        bn_param_oor;

    int n_pass;
    int n_total;

    logic [63:0] ref_mem [512];
    rsp_t exp_q [$];
    rsp_t rsp_log [$];

    bn_param_buf #(.BN_MEM_DEPTH(512), .BN_ADDR_W(9)) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .en_bn_act_proc            (en_bn_act_proc),
        .calfmt                    (calfmt),
        .bn_fixed_point_quat_accrc (quat),
        .bn_is_a_eq_1              (a_eq_1),
        .bn_is_b_eq_0              (b_eq_0),
        .bn_mem_wen_a              (wen),
        .bn_mem_addr_a             (waddr),
        .bn_mem_din_a              (wdin),
        .rd_req_valid              (rd_req_valid),
        .rd_req_ready              (rd_req_ready),
        .rd_req_cid                (rd_req_cid),
        .rd_req_last               (rd_req_last),
        .bn_param_valid            (bn_param_valid),
        .bn_param_ready            (bn_param_ready),
        .bn_param_a                (bn_param_a),
        .bn_param_b                (bn_param_b),
        .bn_param_last             (bn_param_last),
        .bn_param_oor              (bn_param_oor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [65:0] act,
                       input logic [65:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic rsp_t model(input logic [15:0] cid,
                                   input logic last);
        rsp_t r;
        logic [63:0] d;
        r.oor  = (cid >= 16'd512);
        r.last = last;
        d = r.oor ? 64'd0 : ref_mem[cid[8:0]];
        r.a = d[31:0];
        r.b = d[63:32];
        if (a_eq_1) r.a = (calfmt == 2'd2) ? 32'h3F80_0000 : (32'd1 << quat);
        if (b_eq_0) r.b = 32'd0;
        return r;
    endfunction

    always @(negedge clk) begin
        rsp_t got;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bn_param_valid) begin
                got = {bn_param_last, bn_param_oor, bn_param_b, bn_param_a};
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 66'(bn_param_valid), 66'd0);
                end else begin
                    chk("rsp", got, exp_q[0]);
                    if (bn_param_ready) begin
                        rsp_log.push_back(got);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (!en_bn_act_proc) begin
                chk("ready_en_low", 66'(rd_req_ready), 66'd0);
                exp_q.delete();
            end else if (rd_req_valid && rd_req_ready) begin
                exp_q.push_back(model(rd_req_cid, rd_req_last));
            end
            if (wen && waddr < 16'd512) ref_mem[waddr[8:0]] = wdin;
        end
    end

    task automatic wr(input logic [15:0] addr, input logic [63:0] data);
        wen   = 1'b1;
        waddr = addr;
        wdin  = data;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic rd(input logic [15:0] cid, input logic last);
        int n = 0;
        rd_req_valid = 1'b1;
        rd_req_cid   = cid;
        rd_req_last  = last;
        forever begin
            @(negedge clk);
            if (rd_req_ready) break;
            n++;
            if (n > 50) begin
                chk("rd_accept_timeout", 66'(rd_req_ready), 66'd1);
                break;
            end
        end
        @(posedge clk); #1;
        rd_req_valid = 1'b0;
        rd_req_last  = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (rsp_log.size() < n && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rsp_count", 66'(rsp_log.size()), 66'(n));
        @(posedge clk); #1;
    endtask

    initial begin
        int n_acc;
        logic acc;
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        en_bn_act_proc = 1'b1;
        calfmt = 2'd1;
        quat = 5'd0;
        a_eq_1 = 1'b0;
        b_eq_0 = 1'b0;
        wen = 1'b0;
        waddr = '0;
        wdin = '0;
        rd_req_valid = 1'b0;
        rd_req_cid = '0;
        rd_req_last = 1'b0;
        bn_param_ready = 1'b1;

        repeat (2) @(negedge clk);
        chk("rst_ready", 66'(rd_req_ready), 66'd0);
        chk("rst_valid", 66'(bn_param_valid), 66'd0);
        chk("rst_outs", {bn_param_last, bn_param_oor, bn_param_b, bn_param_a},
            66'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // basic reads
        for (int i = 0; i < 5; i++)
            wr(16'(i), {32'(32'h100 * i), 32'(i + 1)});
        rsp_log.delete();
        for (int i = 0; i < 4; i++) rd(16'(i), i == 3);
        wait_rsp(4);
        chk("basic_a0", 66'(rsp_log[0].a), 66'd1);
        chk("basic_b1", 66'(rsp_log[1].b), 66'h100);
        chk("basic_a3", 66'(rsp_log[3].a), 66'd4);
        chk("basic_b3", 66'(rsp_log[3].b), 66'h300);
        chk("basic_last3", 66'(rsp_log[3].last), 66'd1);
        chk("basic_last0", 66'(rsp_log[0].last), 66'd0);

        // first-response latency from an idle pipeline
        rd(16'd1, 1'b0);
        @(negedge clk); chk("lat_c0", 66'(bn_param_valid), 66'd0);
        @(negedge clk); chk("lat_c1", 66'(bn_param_valid), 66'd0);
        @(negedge clk); chk("lat_c2", 66'(bn_param_valid), 66'd1);
        @(posedge clk); #1;
        rsp_log.delete();

        // backpressure
        bn_param_ready = 1'b0;
        n_acc = 0;
        rd_req_valid = 1'b1;
        rd_req_cid = 16'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = rd_req_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                rd_req_cid = 16'(n_acc);
            end
        end
        chk("bp_accepted", 66'(n_acc), 66'd3);
        @(negedge clk);
        chk("bp_ready_low", 66'(rd_req_ready), 66'd0);
        @(posedge clk); #1;
        bn_param_ready = 1'b1;
        for (int c = 0; c < 30 && n_acc < 5; c++) begin
            rd_req_last = (rd_req_cid == 16'd4);
            @(negedge clk);
            acc = rd_req_ready;
            @(posedge clk); #1;
            if (acc) begin
                n_acc++;
                rd_req_cid = 16'(n_acc);
            end
        end
        rd_req_valid = 1'b0;
        rd_req_last = 1'b0;
        chk("bp_total", 66'(n_acc), 66'd5);
        wait_rsp(5);
        chk("bp_a0", 66'(rsp_log[0].a), 66'd1);
        chk("bp_a2", 66'(rsp_log[2].a), 66'd3);
        chk("bp_a4", 66'(rsp_log[4].a), 66'd5);
        chk("bp_b4", 66'(rsp_log[4].b), 66'h400);
        rsp_log.delete();

        // overrides
        wr(16'd7, {32'hDEAD, 32'hBEEF});
        calfmt = 2'd1; quat = 5'd12; a_eq_1 = 1'b1; b_eq_0 = 1'b1;
        rd(16'd7, 1'b0);
        wait_rsp(1);
        chk("ovr_int_a", 66'(rsp_log[0].a), 66'h1000);
        chk("ovr_int_b", 66'(rsp_log[0].b), 66'd0);
        calfmt = 2'd2;
        rd(16'd7, 1'b0);
        wait_rsp(2);
        chk("ovr_fp_a", 66'(rsp_log[1].a), 66'h3F80_0000);
        calfmt = 2'd0; quat = 5'd3;
        rd(16'd7, 1'b0);
        wait_rsp(3);
        chk("ovr_int8_a", 66'(rsp_log[2].a), 66'd8);
        calfmt = 2'd1; a_eq_1 = 1'b0; b_eq_0 = 1'b0;
        rd(16'd7, 1'b0);
        wait_rsp(4);
        chk("ovr_off_a", 66'(rsp_log[3].a), 66'hBEEF);
        chk("ovr_off_b", 66'(rsp_log[3].b), 66'hDEAD);
        rsp_log.delete();

        // read/write collision
        wr(16'd5, {32'd1, 32'd1});
        wen = 1'b1; waddr = 16'd5; wdin = {32'd2, 32'd2};
        rd_req_valid = 1'b1; rd_req_cid = 16'd5;
        @(negedge clk);
        chk("col_ready", 66'(rd_req_ready), 66'd1);
        @(posedge clk); #1;
        wen = 1'b0; rd_req_valid = 1'b0;
        rd(16'd5, 1'b0);
        wait_rsp(2);
        chk("col_old_a", 66'(rsp_log[0].a), 66'd1);
        chk("col_old_b", 66'(rsp_log[0].b), 66'd1);
        chk("col_new_a", 66'(rsp_log[1].a), 66'd2);
        chk("col_new_b", 66'(rsp_log[1].b), 66'd2);
        rsp_log.delete();

        // out of range
        wr(16'd88, {32'h8800, 32'h58});
        wr(16'd600, {32'hFF, 32'hFF});
        rd(16'd600, 1'b0);
        rd(16'd88, 1'b0);
        wait_rsp(2);
        chk("oor_flag", 66'(rsp_log[0].oor), 66'd1);
        chk("oor_a", 66'(rsp_log[0].a), 66'd0);
        chk("oor_b", 66'(rsp_log[0].b), 66'd0);
        chk("alias_a", 66'(rsp_log[1].a), 66'h58);
        chk("alias_oor", 66'(rsp_log[1].oor), 66'd0);
        rsp_log.delete();

        // enable drop
        bn_param_ready = 1'b0;
        rd(16'd2, 1'b0);
        rd(16'd3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        en_bn_act_proc = 1'b0;
        @(posedge clk); #1;
        en_bn_act_proc = 1'b1;
        @(negedge clk);
        chk("en_drop_valid", 66'(bn_param_valid), 66'd0);
        @(posedge clk); #1;
        bn_param_ready = 1'b1;
        rd(16'd0, 1'b0);
        wait_rsp(1);
        chk("en_retain_a", 66'(rsp_log[0].a), 66'd1);
        rsp_log.delete();

        // reset mid-transfer
        bn_param_ready = 1'b0;
        rd(16'd1, 1'b0);
        rd(16'd2, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", 66'(bn_param_valid), 66'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_rst_valid", 66'(bn_param_valid), 66'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
